// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Radix-2 restoring, one quotient bit per clock; divide-by-zero and signed overflow resolve in one cycle.
//
// state | meaning
// IDLE  | waiting for an un-annulled start_i; operands captured on start
// BUSY  | one restoring iteration per cycle, DATA_W iterations total
// DONE  | result_o valid, ready_o pulses unless annulled; always returns to IDLE
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              rem_i,
    input  logic              annul_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DATA_W-1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              neg_q;
    logic              neg_r;
    logic              rem_sel;

    logic              start_ok;
    logic              div_zero;
    logic              overflow;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dvs_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              no_borrow;
    logic [DATA_W-1:0] quo_nxt;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    always_comb begin
        start_ok  = start_i & ~annul_i;
        div_zero  = (divisor_i == '0);
        overflow  = signed_i && (dividend_i == MIN_NEG) && (divisor_i == '1);
        // Negating MIN_NEG wraps to itself, which is the correct unsigned magnitude.
        dvd_mag   = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
        dvs_mag   = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

        // One extra bit keeps the trial subtract exact for divisor magnitudes >= 2^(DATA_W-1).
        shifted   = {rem, quo[DATA_W-1]};
        diff      = shifted - {1'b0, dvs};
        no_borrow = ~diff[DATA_W];
        quo_nxt   = {quo[DATA_W-2:0], no_borrow};
        rem_nxt   = no_borrow ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_fix   = neg_q ? -quo_nxt : quo_nxt;
        rem_fix   = neg_r ? -rem_nxt : rem_nxt;

        stallreq_o = rst & (((state == IDLE) & start_ok) | ((state == BUSY) & ~annul_i));
        ready_o    = (state == DONE) & ~annul_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem_sel  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        neg_q   <= signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                        neg_r   <= signed_i & dividend_i[DATA_W-1];
                        rem_sel <= rem_i;
                        dvs     <= dvs_mag;
                        quo     <= dvd_mag;
                        rem     <= '0;
                        cnt     <= '0;
                        if (div_zero) begin
                            result_o <= rem_i ? dividend_i : '1;
                            state    <= DONE;
                        end else if (overflow) begin
                            result_o <= rem_i ? '0 : MIN_NEG;
                            state    <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        quo <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            result_o <= rem_sel ? rem_fix : quo_fix;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall length, results, flush and async reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        rem_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .rem_i      (rem_i),
        .annul_i    (annul_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start on a negedge, hold start_i until ready_o, then drop it and return to IDLE.
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic sgn, input logic rm, input logic [31:0] exp_res,
                          input int exp_lat);
        int          cyc;
        int          stalls;
        int          lat;
        logic [31:0] res;
        logic        overlap;
        @(negedge clk);
        dividend_i = dvd;
        divisor_i  = dvs;
        signed_i   = sgn;
        rem_i      = rm;
        start_i    = 1'b1;
        #1;
        cyc = 0; stalls = 0; lat = -1; res = '0; overlap = 1'b0;
        while (cyc < 40 && lat < 0) begin
            if (stallreq_o) stalls++;
            if (ready_o) begin
                lat     = cyc;
                res     = result_o;
                overlap = stallreq_o;
                start_i = 1'b0;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start_i = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_lat));
        chk({tag, " result"}, res, exp_res);
        chk({tag, " ready/stall overlap"}, {31'd0, overlap}, 32'd0);
        @(posedge clk); #1;
        chk({tag, " ready after done"}, {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        int pulses;
        #12;
        chk("reset result", result_o, 32'd0);
        chk("reset ready", {31'd0, ready_o}, 32'd0);
        chk("reset stall", {31'd0, stallreq_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("divu 100/7", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, 33);
        run_op("rem -7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 33);
        run_op("div -7/2",   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
        run_op("divu by 0",  32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);
        run_op("remu by 0",  32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1);
        run_op("div ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1);
        run_op("rem ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1);
        run_op("divu ovf operands", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 33);
        run_op("rem 7/-2",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0001, 33);
        run_op("div 7/-2",   32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
        run_op("remu big",   32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 32'h7FFF_FFFE, 33);

        // Flush in BUSY cycle 10.
        @(negedge clk);
        dividend_i = 32'd1000; divisor_i = 32'd3; signed_i = 1'b0; rem_i = 1'b0;
        start_i = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        start_i = 1'b0;
        #1;
        chk("flush stall drop", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("flush idle stall", {31'd0, stallreq_o}, 32'd0);
        pulses = 0;
        repeat (35) begin
            if (ready_o) pulses++;
            @(posedge clk); #1;
        end
        chk("flush no ready", 32'(pulses), 32'd0);
        run_op("divu 9/3 after flush", 32'd9, 32'd3, 1'b0, 1'b0, 32'd3, 33);

        // Annul in DONE suppresses the ready pulse.
        @(negedge clk);
        dividend_i = 32'd5; divisor_i = 32'd0; signed_i = 1'b0; rem_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        annul_i = 1'b1;
        #1;
        chk("annul in done ready", {31'd0, ready_o}, 32'd0);
        chk("annul in done stall", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("annul in done after", {31'd0, ready_o}, 32'd0);

        // Asynchronous reset mid-operation, start_i still held.
        @(negedge clk);
        dividend_i = 32'd1000; divisor_i = 32'd3; signed_i = 1'b0; rem_i = 1'b0;
        start_i = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        chk("async rst stall", {31'd0, stallreq_o}, 32'd0);
        chk("async rst ready", {31'd0, ready_o}, 32'd0);
        chk("async rst result", result_o, 32'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("divu 100/7 after rst", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
